// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/clear sequencer for the stopwatch digit chain: debounces the two
// push keys, paces the hundredths tick and drives clear/hold for the display.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  output logic       tick,
  output logic       clear,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("stopwatch_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end

  // Bit 0 is the start/stop key, bit 1 the lap/clear key.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r, sync2_r, deb_r, deb_d_r, press_r;
  logic [CW-1:0] cnt_r [2];
  logic          start_ev_s, lap_ev_s;
  state_e        state_r, next_s;
  logic [PW-1:0] presc_r;
  logic          tick_r, clear_r, hold_r, running_r;

  assign raw_s = {key_lap_n, key_start_n};

  // Key synchronizers, debounce counters and registered press detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r  <= 2'b11;
      sync2_r  <= 2'b11;
      deb_r    <= 2'b11;
      deb_d_r  <= 2'b11;
      press_r  <= 2'b00;
      cnt_r[0] <= {CW{1'b0}};
      cnt_r[1] <= {CW{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      press_r <= deb_d_r & ~deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (cnt_r[i] == DEB_LAST) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= {CW{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + 1'b1;
        end
      end
    end
  end

  // A start press takes priority; a simultaneous lap press is dropped.
  assign start_ev_s = press_r[0];
  assign lap_ev_s   = press_r[1] & ~press_r[0];

  // Next-state selection from the key events.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ev_s) next_s = ST_RUN;
        else            next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start_ev_s)    next_s = ST_STOP;
        else if (lap_ev_s) next_s = ST_LAP;
        else               next_s = ST_RUN;
      end
      ST_LAP: begin
        if (start_ev_s)    next_s = ST_STOP;
        else if (lap_ev_s) next_s = ST_RUN;
        else               next_s = ST_LAP;
      end
      ST_STOP: begin
        if (start_ev_s)    next_s = ST_RUN;
        else if (lap_ev_s) next_s = ST_IDLE;
        else               next_s = ST_STOP;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State register, prescaler and registered outputs; STOP freezes the phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      presc_r   <= {PW{1'b0}};
      tick_r    <= 1'b0;
      clear_r   <= 1'b1;
      hold_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      clear_r   <= (next_s == ST_IDLE);
      hold_r    <= (next_s == ST_LAP);
      running_r <= (next_s == ST_RUN) || (next_s == ST_LAP);
      if (state_r == ST_RUN || state_r == ST_LAP) begin
        if (presc_r == PRESC_LAST) begin
          presc_r <= {PW{1'b0}};
          tick_r  <= 1'b1;
        end else begin
          presc_r <= presc_r + 1'b1;
          tick_r  <= 1'b0;
        end
      end else if (state_r == ST_STOP && next_s != ST_IDLE) begin
        presc_r <= presc_r;
        tick_r  <= 1'b0;
      end else begin
        presc_r <= {PW{1'b0}};
        tick_r  <= 1'b0;
      end
    end
  end

  assign state   = state_r;
  assign tick    = tick_r;
  assign clear   = clear_r;
  assign hold    = hold_r;
  assign running = running_r;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/stop/lap/clear sequencer for the stopwatch's cascaded BCD digit counters.
- Debounces the two DE10-Lite push keys and derives a one-cycle tick enable from the board clock that drives the hundredths-digit counter's enable.
- Issues a clear to the counters and a display hold for lap freeze.
- Sits between the KEY pins and the counter chain / 7-seg display latch.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 100, tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer >= 2; any other value is an elaboration error.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a key level change. Must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- key_start_n  in  1  raw start/stop key, active-low, asynchronous.
- key_lap_n  in  1  raw lap/clear key, active-low, asynchronous.
- tick  out  1  one-cycle enable pulse to the hundredths counter.
- clear  out  1  synchronous clear to all digit counters; the counters use reset|clear.
- hold  out  1  display latch freeze (lap view).
- running  out  1  high in RUN or LAP.
- state  out  2  IDLE=0, RUN=1, LAP=2, STOP=3.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on port `reset`.
- All outputs are registered.
- Reset values: state=IDLE, tick=0, clear=1, hold=0, running=0, prescaler=0.
- Both synchronizer flops and both debounced levels reset to released (1).
- Reset in any state returns the block to IDLE on the next edge.

Key input path:
- Each key passes through a 2-flop synchronizer and then a debounce counter.
- The debounce counter resets whenever the synchronized level differs from the debounced level.
- When the two levels have differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates.
- A press event is a one-cycle pulse on the debounced 1->0 transition. Release produces no event.
- Latency L = DEBOUNCE_CYCLES+3 edges, measured from the first edge sampling a stable new raw level to the state register update.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- A held key produces exactly one event.
- A key held through reset produces one event, L cycles after reset deasserts.
- Same-cycle start and lap events: start wins and lap is dropped.

FSM (transitions take effect on the edge after the event):
- IDLE: clear=1, tick=0, hold=0, prescaler=0. start -> RUN. lap ignored.
- RUN: clear=0, hold=0. start -> STOP. lap -> LAP.
- LAP: as RUN but hold=1; ticks continue. lap -> RUN (hold=0). start -> STOP (hold=0).
- STOP: tick=0, hold=0, prescaler frozen at its current value, so resume keeps sub-tick phase. start -> RUN. lap -> IDLE.

Prescaler:
- Width clog2(DIV). Counts only in RUN/LAP.
- At DIV-1 it wraps to 0 and tick=1 for the following cycle.
- With k=0 the first cycle state==RUN after IDLE, tick is high at k=DIV, 2*DIV, ... and never on two consecutive cycles.
- Entering STOP on the same edge that a wrap occurs: that tick is still emitted, and none follow.
- The RUN<->LAP transition does not disturb prescaler phase.
- clear is high exactly while state==IDLE; its first cycle high is the cycle after the STOP->IDLE edge.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_CYCLES=4 (L=7).
1. Reset, then press start (hold low 20 cycles) -> state IDLE->RUN 7 edges after first low sample. clear drops with the transition. tick at k=10,20,30; exactly 3 ticks in k=0..30.
2. In RUN at prescaler=6, press start -> STOP, tick stays 0 for 50 cycles. Press start again -> first tick exactly 3 cycles after re-entering RUN.
3. In RUN, press lap -> hold=1, ticks continue at 10-cycle spacing. Press lap again -> hold=0, RUN, no phase slip.
4. Start key bouncing low 3 cycles / high 2 cycles ×5, then stable high -> no state change and no tick.
5. In STOP, press start and lap in the same cycle -> RUN only; clear stays 0. Then start again -> STOP; lap -> IDLE, clear=1, state=0.
6. Assert reset for 1 cycle while in LAP mid-prescale -> next cycle state=0, tick=0, hold=0, clear=1, running=0.
